lif_neuron: RTL and testbench

Parametrised leaky integrate-and-fire neuron for the SNN datapath. It is the next generation of the fixed three-input threshold stage. It sums `N_IN` unsigned synaptic inputs per timestep into a persistent saturating membrane potential, with optional leak. It emits a one-step spike when the potential reaches `THRESHOLD`, then holds off for a refractory period. Instances sit between layer stages: one per neuron, driven by the previous layer's per-timestep outputs.

---
 rtl/snn_pkg.sv | 29 ++
 rtl/snn_input_adder.sv | 19 +
 rtl/lif_neuron.sv | 115 +++++++++++
 tb/tb_lif_neuron.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared types and helpers for the SNN datapath: LIF state encoding,
// a saturating unsigned adder and counter-width helper.
package snn_pkg;

  typedef enum logic {
    INTEG   = 1'b0,
    REFRACT = 1'b1
  } lif_state_t;

  // Widest operand sat_add supports; callers truncate the result to their width.
  localparam int unsigned SNN_MAX_W = 32;

  // Width of a down-counter that must hold the value n (never narrower than 1).
  function automatic int snn_cnt_w(input int unsigned n);
    return (n == 0) ? 1 : $clog2(n + 1);
  endfunction

  // Unsigned a + b clamped to 2^w - 1, for any w in 1..SNN_MAX_W.
  function automatic logic [SNN_MAX_W-1:0] sat_add(input logic [SNN_MAX_W-1:0] a,
                                                    input logic [SNN_MAX_W-1:0] b,
                                                    input int unsigned          w);
    logic [SNN_MAX_W:0] s;
    logic [SNN_MAX_W:0] lim;
    s   = {1'b0, a} + {1'b0, b};
    lim = {(SNN_MAX_W + 1){1'b1}} >> (SNN_MAX_W + 1 - w);
    return SNN_MAX_W'((s > lim) ? lim : s);
  endfunction

endpackage

// File: rtl/snn_input_adder.sv
// Combinational N_IN-way unsigned adder; the result is exact at full width
// and never overflows.
module snn_input_adder #(
  parameter int N_IN   = 3,
  parameter int DATA_W = 8,
  parameter int SUM_W  = DATA_W + $clog2(N_IN)
) (
  input  logic [N_IN*DATA_W-1:0] i_data,
  output logic [SUM_W-1:0]       o_sum
);

  always_comb begin
    o_sum = '0;
    for (int k = 0; k < N_IN; k++) begin
      o_sum = o_sum + SUM_W'(i_data[k*DATA_W +: DATA_W]);
    end
  end

endmodule

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron with saturating membrane and refractory hold-off.
// Leak is compiled in only when LIF_LEAK_EN is defined.
//
// state   | meaning
// INTEG   | accumulating inputs into v; fires when v reaches THRESHOLD
// REFRACT | v held at 0, inputs discarded until the counter reaches 0
module lif_neuron
  import snn_pkg::*;
#(
  parameter int N_IN          = 3,
  parameter int DATA_W        = 8,
  parameter int V_W           = 12,
  parameter int THRESHOLD     = 100,
  parameter int REFRACT_STEPS = 2,
  parameter int LEAK_SHIFT    = 3
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  input  logic                   i_valid,
  input  logic [N_IN*DATA_W-1:0] i_data,
  input  logic                   i_clear,
  output logic                   o_valid,
  output logic                   o_spike,
  output logic [V_W-1:0]         o_vmem,
  output logic                   o_refractory
);

  localparam int               SUM_W    = DATA_W + $clog2(N_IN);
  localparam int               CNT_W    = snn_cnt_w(REFRACT_STEPS);
  localparam logic [V_W-1:0]   THR      = V_W'(THRESHOLD);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(REFRACT_STEPS);

  if (V_W > SNN_MAX_W || V_W < SUM_W || THRESHOLD < 1 || (THRESHOLD >> V_W) != 0 ||
      REFRACT_STEPS < 0 || LEAK_SHIFT < 1 || LEAK_SHIFT >= V_W) begin : g_bad_cfg
    $error("lif_neuron: illegal parameter combination");
  end

  logic [SUM_W-1:0] sum;
  logic [V_W-1:0]   vl;
  logic [V_W-1:0]   vn;

  lif_state_t       state_q, state_d;
  logic [V_W-1:0]   v_q, v_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             spike_q, spike_d;

  snn_input_adder #(
    .N_IN   (N_IN),
    .DATA_W (DATA_W),
    .SUM_W  (SUM_W)
  ) u_adder (
    .i_data (i_data),
    .o_sum  (sum)
  );

  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    spike_d = 1'b0;
`ifdef LIF_LEAK_EN
    vl = v_q - (v_q >> LEAK_SHIFT);
`else
    vl = v_q;
`endif
    vn = V_W'(sat_add(SNN_MAX_W'(vl), SNN_MAX_W'(sum), V_W));

    if (i_clear) begin
      state_d = INTEG;
      v_d     = '0;
      cnt_d   = '0;
    end else if (i_valid) begin
      valid_d = 1'b1;
      if (state_q == INTEG) begin
        if (vn >= THR) begin
          spike_d = 1'b1;
          v_d     = '0;
          cnt_d   = CNT_INIT;
          state_d = (REFRACT_STEPS > 0) ? REFRACT : INTEG;
        end else begin
          v_d = vn;
        end
      end else begin
        // Counter is nonzero on entry to REFRACT; leave when this step empties it.
        v_d   = '0;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = INTEG;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= INTEG;
      v_q     <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      spike_q <= 1'b0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      spike_q <= spike_d;
    end
  end

  assign o_valid      = valid_q;
  assign o_spike      = spike_q;
  assign o_vmem       = v_q;
  assign o_refractory = (state_q == REFRACT);

endmodule

// File: tb/tb_lif_neuron.sv
// Bench for lif_neuron: directed scenarios pinned by literals, then random
// steps compared every cycle against an arithmetic neuron model.
module tb_lif_neuron;

  localparam int N_IN          = 3;
  localparam int DATA_W        = 8;
  localparam int V_W           = 12;
  localparam int THRESHOLD     = 100;
  localparam int REFRACT_STEPS = 2;
  localparam int LEAK_SHIFT    = 3;
  localparam int VMAX          = (1 << V_W) - 1;

  logic i_clk = 1'b0;
  logic i_rstn = 1'b0;
  always #5 i_clk = ~i_clk;

  logic                   i_valid = 1'b0;
  logic                   i_clear = 1'b0;
  logic [N_IN*DATA_W-1:0] i_data  = '0;
  logic                   o_valid, o_spike, o_refractory;
  logic [V_W-1:0]         o_vmem;

  logic                   s_valid = 1'b0;
  logic                   s_clear = 1'b0;
  logic [N_IN*DATA_W-1:0] s_data  = '0;
  logic                   s_o_valid, s_o_spike, s_o_refractory;
  logic [V_W-1:0]         s_o_vmem;

  lif_neuron #(
    .N_IN(N_IN), .DATA_W(DATA_W), .V_W(V_W), .THRESHOLD(THRESHOLD),
    .REFRACT_STEPS(REFRACT_STEPS), .LEAK_SHIFT(LEAK_SHIFT)
  ) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_valid(i_valid), .i_data(i_data),
    .i_clear(i_clear), .o_valid(o_valid), .o_spike(o_spike),
    .o_vmem(o_vmem), .o_refractory(o_refractory)
  );

  lif_neuron #(
    .N_IN(N_IN), .DATA_W(DATA_W), .V_W(V_W), .THRESHOLD(4095),
    .REFRACT_STEPS(REFRACT_STEPS), .LEAK_SHIFT(LEAK_SHIFT)
  ) dut_sat (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_valid(s_valid), .i_data(s_data),
    .i_clear(s_clear), .o_valid(s_o_valid), .o_spike(s_o_spike),
    .o_vmem(s_o_vmem), .o_refractory(s_o_refractory)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference neuron: potential, refractory steps still owed, last step result.
  int m_v   = 0;
  int m_rem = 0;
  bit m_valid = 1'b0;
  bit m_spike = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N_IN*DATA_W-1:0] pack3(input int a, input int b, input int c);
    return {DATA_W'(c), DATA_W'(b), DATA_W'(a)};
  endfunction

  function automatic int in_sum(input logic [N_IN*DATA_W-1:0] d);
    int s = 0;
    for (int k = 0; k < N_IN; k++) s += int'(d[k*DATA_W +: DATA_W]);
    return s;
  endfunction

  task automatic model_reset();
    m_v = 0; m_rem = 0; m_valid = 1'b0; m_spike = 1'b0;
  endtask

  task automatic model_step(input bit v, input bit c, input logic [N_IN*DATA_W-1:0] d);
    int vl, vn;
    m_spike = 1'b0;
    if (c) begin
      m_v = 0; m_rem = 0; m_valid = 1'b0;
    end else if (!v) begin
      m_valid = 1'b0;
    end else begin
      m_valid = 1'b1;
      if (m_rem > 0) begin
        m_rem--;
        m_v = 0;
      end else begin
`ifdef LIF_LEAK_EN
        vl = m_v - m_v / (2 ** LEAK_SHIFT);
`else
        vl = m_v;
`endif
        vn = vl + in_sum(d);
        if (vn > VMAX) vn = VMAX;
        if (vn >= THRESHOLD) begin
          m_spike = 1'b1; m_v = 0; m_rem = REFRACT_STEPS;
        end else begin
          m_v = vn;
        end
      end
    end
  endtask

  // Present one cycle of input; returns 1 time unit after the capturing edge.
  task automatic step(input bit v, input bit c, input logic [N_IN*DATA_W-1:0] d);
    i_valid = v; i_clear = c; i_data = d;
    @(posedge i_clk); #1;
    model_step(v, c, d);
    i_valid = 1'b0; i_clear = 1'b0;
  endtask

  task automatic do_reset(input bit valid_during);
    i_valid = valid_during; i_data = pack3(40, 40, 40);
    i_rstn = 1'b0;
    model_reset();
    @(posedge i_clk); #1;
    i_rstn = 1'b1; i_valid = 1'b0;
  endtask

  always @(negedge i_clk) begin
    if (chk_en) begin
      check("o_valid", o_valid, m_valid);
      check("o_spike", o_spike, m_spike);
      check("o_vmem", o_vmem, m_v);
      check("o_refractory", o_refractory, m_rem > 0);
    end
  end

  initial begin
`ifdef LIF_LEAK_EN
    int exp_int[4] = '{30, 57, 80, 0};
`else
    int exp_int[4] = '{30, 60, 90, 0};
`endif
    repeat (2) @(posedge i_clk);
    #1 i_rstn = 1'b1;
    chk_en = 1'b1;

    check("rst_valid", o_valid, 0);
    check("rst_spike", o_spike, 0);
    check("rst_vmem", o_vmem, 0);
    check("rst_refr", o_refractory, 0);

    // Saturating accumulation on the THRESHOLD=4095 instance.
    for (int i = 1; i <= 6; i++) begin
      s_valid = 1'b1; s_data = pack3(255, 255, 255);
      step(0, 0, '0);
      s_valid = 1'b0;
`ifndef LIF_LEAK_EN
      check("sat_vmem", s_o_vmem, (i < 6) ? 765 * i : 0);
      check("sat_spike", s_o_spike, i == 6);
`endif
    end

    for (int i = 0; i < 4; i++) begin
      step(1, 0, pack3(10, 10, 10));
      check("int_vmem", o_vmem, exp_int[i]);
      check("int_model", m_v, exp_int[i]);
      check("int_spike", o_spike, i == 3);
    end
    check("refr_after_spike", o_refractory, 1);

    for (int i = 0; i < 2; i++) begin
      check("refr_flag", o_refractory, 1);
      step(1, 0, pack3(255, 255, 255));
      check("refr_spike", o_spike, 0);
      check("refr_vmem", o_vmem, 0);
      repeat (3) step(0, 0, '0);
    end
    step(1, 0, pack3(255, 255, 255));
    check("refr_end_spike", o_spike, 1);

    repeat (2) step(1, 0, '0);
    repeat (3) step(1, 0, pack3(10, 10, 10));
    check("pre_clear_vmem", o_vmem, exp_int[2]);
    step(1, 1, pack3(10, 10, 10));
    check("clr_valid", o_valid, 0);
    check("clr_vmem", o_vmem, 0);
    step(1, 0, pack3(10, 10, 10));
    check("post_clr_vmem", o_vmem, 30);

    step(1, 0, pack3(40, 40, 40));
    check("pre_rst_spike", o_spike, 1);
    step(0, 0, '0);
    check("pre_rst_refr", o_refractory, 1);
    do_reset(1'b1);
    check("rst_refr2", o_refractory, 0);
    check("rst_vmem2", o_vmem, 0);
    check("rst_valid2", o_valid, 0);
    step(0, 0, '0);
    check("rst_no_valid", o_valid, 0);
    step(1, 0, pack3(40, 40, 40));
    check("post_rst_spike", o_spike, 1);

    for (int n = 0; n < 4000; n++) begin
      int hi;
      bit v, c;
      if ($urandom_range(0, 999) == 0) begin
        do_reset(1'($urandom_range(0, 1)));
      end else begin
        hi = ($urandom_range(0, 9) == 0) ? 255 : 40;
        v  = ($urandom_range(0, 99) < 70);
        c  = ($urandom_range(0, 99) < 4);
        step(v, c, pack3($urandom_range(0, hi), $urandom_range(0, hi), $urandom_range(0, hi)));
      end
    end

    repeat (2) step(0, 0, '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
